// File: rtl/fetch_unit24_if.sv
// fetch_unit24_if
//   Fetch-to-decode handshake bundle.
//   instr_valid  fetch -> decode  instr_out/pc_out carry a valid instruction
//   instr_ready  decode -> fetch  decode accepts when instr_valid && instr_ready
//   instr_out    fetch -> decode  fetched instruction word
//   pc_out       fetch -> decode  address instr_out was fetched from
//   Modports: master = fetch side, slave = decode side.
interface fetch_unit24_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 24
);
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;

  modport master (
    output instr_valid,
    output instr_out,
    output pc_out,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_out,
    input  pc_out,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit24.sv
// fetch_unit24
//   Instruction fetch stage in front of a ROM with a 1-cycle registered read.
//   Holds the PC, issues one ROM read per cycle when there is room, and absorbs
//   the ROM latency with an output register plus a skid register so decode sees
//   one instruction per cycle and backpressure never loses a landing word.
//   Branch redirect squashes everything held or in flight and restarts at redirect_pc.
// Ports
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   fetch_en     1 = new ROM reads may issue; in-flight data always completes
//   rom_addr     ROM address, equal to the pc register
//   rom_instr    ROM data, valid the cycle after rom_addr was issued
//   redirect     taken branch/jump: squash and restart at redirect_pc
//   redirect_pc  redirect target
//   dec          decode handshake (instr_valid/instr_ready/instr_out/pc_out)
module fetch_unit24 #(
  parameter int                ADDR_W   = 10,
  parameter int                INSTR_W  = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [INSTR_W-1:0]  rom_instr,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  fetch_unit24_if.master      dec
);

  logic [ADDR_W-1:0]  pc, pc_nxt;
  logic               inflight, inflight_nxt;
  logic [ADDR_W-1:0]  inflight_pc, inflight_pc_nxt;
  logic               out_valid, out_valid_nxt;
  logic [INSTR_W-1:0] out_instr, out_instr_nxt;
  logic [ADDR_W-1:0]  out_pc, out_pc_nxt;
  logic               skid_valid, skid_valid_nxt;
  logic [INSTR_W-1:0] skid_instr, skid_instr_nxt;
  logic [ADDR_W-1:0]  skid_pc, skid_pc_nxt;

  logic               deq;
  logic [1:0]         occ;
  logic [1:0]         occ_after;
  logic               issue;

  assign rom_addr        = pc;
  assign dec.instr_valid = out_valid;
  assign dec.instr_out   = out_instr;
  assign dec.pc_out      = out_pc;

  // Issue decision: a read may go out only if, after this cycle's dequeue,
  // there is still a free slot for the word that will land next cycle.
  always_comb begin
    deq       = out_valid & dec.instr_ready;
    occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight};
    occ_after = occ - {1'b0, deq};
    issue     = fetch_en & ~redirect & (occ_after < 2'd2);
  end

  // Next-state for pc, in-flight tracking and the out/skid buffer pair.
  always_comb begin
    out_valid_nxt   = out_valid & ~deq;
    out_instr_nxt   = out_instr;
    out_pc_nxt      = out_pc;
    skid_valid_nxt  = skid_valid;
    skid_instr_nxt  = skid_instr;
    skid_pc_nxt     = skid_pc;
    inflight_nxt    = issue;
    inflight_pc_nxt = inflight_pc;
    pc_nxt          = pc;

    if (redirect) begin
      // Squash: the read in flight (if any) is dropped by clearing inflight.
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
      pc_nxt         = redirect_pc;
    end else begin
      if (issue) begin
        inflight_pc_nxt = pc;
        pc_nxt          = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        pc_nxt          = pc;
      end

      // Older word in skid moves forward before any landing word.
      if (!out_valid_nxt && skid_valid) begin
        out_valid_nxt  = 1'b1;
        out_instr_nxt  = skid_instr;
        out_pc_nxt     = skid_pc;
        skid_valid_nxt = 1'b0;
      end else begin
        skid_valid_nxt = skid_valid;
      end

      // Landing word fills out if free, otherwise parks in skid.
      if (inflight) begin
        if (!out_valid_nxt) begin
          out_valid_nxt  = 1'b1;
          out_instr_nxt  = rom_instr;
          out_pc_nxt     = inflight_pc;
        end else begin
          skid_valid_nxt = 1'b1;
          skid_instr_nxt = rom_instr;
          skid_pc_nxt    = inflight_pc;
        end
      end else begin
        inflight_pc_nxt = inflight_pc_nxt;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= {INSTR_W{1'b0}};
      out_pc      <= {ADDR_W{1'b0}};
      skid_valid  <= 1'b0;
      skid_instr  <= {INSTR_W{1'b0}};
      skid_pc     <= {ADDR_W{1'b0}};
    end else begin
      pc          <= pc_nxt;
      inflight    <= inflight_nxt;
      inflight_pc <= inflight_pc_nxt;
      out_valid   <= out_valid_nxt;
      out_instr   <= out_instr_nxt;
      out_pc      <= out_pc_nxt;
      skid_valid  <= skid_valid_nxt;
      skid_instr  <= skid_instr_nxt;
      skid_pc     <= skid_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit24.sv
// tb_fetch_unit24
//   Directed bench: one DUT with RESET_PC=0 driven from a vector table, and a
//   second DUT with RESET_PC=3FE used for the PC wrap sequence.
module tb_fetch_unit24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT 1 (RESET_PC = 0)
  logic        rst1, fen1, redir1;
  logic [9:0]  rpc1, rom_addr1;
  logic [23:0] rom_instr1;
  fetch_unit24_if #(.ADDR_W(10), .INSTR_W(24)) dec1();

  fetch_unit24 #(.ADDR_W(10), .INSTR_W(24), .RESET_PC(10'h000)) dut1 (
    .clk(clk), .rst(rst1), .fetch_en(fen1), .rom_addr(rom_addr1),
    .rom_instr(rom_instr1), .redirect(redir1), .redirect_pc(rpc1), .dec(dec1)
  );

  // DUT 2 (RESET_PC = 3FE)
  logic        rst2, fen2, redir2;
  logic [9:0]  rpc2, rom_addr2;
  logic [23:0] rom_instr2;
  fetch_unit24_if #(.ADDR_W(10), .INSTR_W(24)) dec2();

  fetch_unit24 #(.ADDR_W(10), .INSTR_W(24), .RESET_PC(10'h3FE)) dut2 (
    .clk(clk), .rst(rst2), .fetch_en(fen2), .rom_addr(rom_addr2),
    .rom_instr(rom_instr2), .redirect(redir2), .redirect_pc(rpc2), .dec(dec2)
  );

  // ROM models: ROM[i] = A00000 + i, one-cycle registered read
  always @(posedge clk) begin
    rom_instr1 <= 24'hA00000 + {14'd0, rom_addr1};
    rom_instr2 <= 24'hA00000 + {14'd0, rom_addr2};
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, fen, rdy, redir;
    logic [9:0]  rpc;
    logic        chk, chk_data, exp_valid;
    logic [9:0]  exp_pc, exp_addr;
    logic [23:0] exp_instr;
  } vec_t;

  function automatic vec_t v(input logic rst, input logic fen, input logic rdy,
                             input logic redir, input logic [9:0] rpc,
                             input logic chk, input logic chk_data, input logic ev,
                             input logic [9:0] epc, input logic [9:0] eaddr,
                             input logic [23:0] einstr);
    vec_t r;
    r.rst = rst; r.fen = fen; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
    r.chk = chk; r.chk_data = chk_data; r.exp_valid = ev;
    r.exp_pc = epc; r.exp_addr = eaddr; r.exp_instr = einstr;
    return r;
  endfunction

  localparam int NV = 29;
  vec_t vecs [NV];

  logic [9:0]  wrap_pc [4];
  logic [23:0] wrap_in [4];

  initial begin
    int first;

    //           rst   fen   rdy   rdr   rpc     chk   cd    ev    pc      addr    instr
    vecs[0]  = v(1'b1, 1'b0, 1'b0, 1'b0, 10'h0,  1'b0, 1'b0, 1'b0, 10'h0,  10'h0,  24'h0);
    vecs[1]  = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h000, 24'h0);
    vecs[2]  = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h001, 24'h0);
    vecs[3]  = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h000, 10'h002, 24'hA00000);
    vecs[4]  = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h001, 10'h003, 24'hA00001);
    vecs[5]  = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h002, 10'h004, 24'hA00002);
    vecs[6]  = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h003, 10'h005, 24'hA00003);
    vecs[7]  = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h004, 10'h006, 24'hA00004);
    // backpressure 3 cycles at pc_out=5: output holds, no issue while full
    vecs[8]  = v(1'b0, 1'b1, 1'b0, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h005, 10'h007, 24'hA00005);
    vecs[9]  = v(1'b0, 1'b1, 1'b0, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h005, 10'h007, 24'hA00005);
    vecs[10] = v(1'b0, 1'b1, 1'b0, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h005, 10'h007, 24'hA00005);
    vecs[11] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h005, 10'h007, 24'hA00005);
    vecs[12] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h006, 10'h008, 24'hA00006);
    // stall to fill out=7, skid=8, then redirect to 3F0
    vecs[13] = v(1'b0, 1'b1, 1'b0, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h007, 10'h009, 24'hA00007);
    vecs[14] = v(1'b0, 1'b1, 1'b0, 1'b1, 10'h3F0, 1'b1, 1'b1, 1'b1, 10'h007, 10'h009, 24'hA00007);
    vecs[15] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h3F0, 24'h0);
    vecs[16] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h3F1, 24'h0);
    vecs[17] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h3F0, 10'h3F2, 24'hA003F0);
    // redirect mid-stream with a read in flight (3F2 must be squashed)
    vecs[18] = v(1'b0, 1'b1, 1'b1, 1'b1, 10'h020, 1'b1, 1'b1, 1'b1, 10'h3F1, 10'h3F3, 24'hA003F1);
    vecs[19] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h020, 24'h0);
    vecs[20] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h021, 24'h0);
    // fetch_en low: 021 already issued still delivered, pc frozen at 022
    vecs[21] = v(1'b0, 1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h020, 10'h022, 24'hA00020);
    vecs[22] = v(1'b0, 1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h021, 10'h022, 24'hA00021);
    vecs[23] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h022, 24'h0);
    vecs[24] = v(1'b0, 1'b1, 1'b1, 1'b0, 10'h0,  1'b1, 1'b0, 1'b0, 10'h0,  10'h023, 24'h0);
    // fill out and skid, then reset
    vecs[25] = v(1'b0, 1'b1, 1'b0, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h022, 10'h024, 24'hA00022);
    vecs[26] = v(1'b1, 1'b1, 1'b0, 1'b0, 10'h0,  1'b1, 1'b1, 1'b1, 10'h022, 10'h024, 24'hA00022);
    vecs[27] = v(1'b0, 1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 24'h000000);
    vecs[28] = v(1'b0, 1'b0, 1'b1, 1'b0, 10'h0,  1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 24'h000000);

    wrap_pc[0] = 10'h3FE; wrap_pc[1] = 10'h3FF; wrap_pc[2] = 10'h000; wrap_pc[3] = 10'h001;
    wrap_in[0] = 24'hA003FE; wrap_in[1] = 24'hA003FF; wrap_in[2] = 24'hA00000; wrap_in[3] = 24'hA00001;

    rst1 = 1'b1; fen1 = 1'b0; redir1 = 1'b0; rpc1 = 10'h0; dec1.instr_ready = 1'b0;
    rst2 = 1'b1; fen2 = 1'b0; redir2 = 1'b0; rpc2 = 10'h0; dec2.instr_ready = 1'b0;

    // table-driven run on DUT 1
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst1 = vecs[i].rst; fen1 = vecs[i].fen; dec1.instr_ready = vecs[i].rdy;
      redir1 = vecs[i].redir; rpc1 = vecs[i].rpc;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d_valid", i), {31'd0, dec1.instr_valid}, {31'd0, vecs[i].exp_valid});
        check($sformatf("row%0d_rom_addr", i), {22'd0, rom_addr1}, {22'd0, vecs[i].exp_addr});
      end
      if (vecs[i].chk_data) begin
        check($sformatf("row%0d_pc_out", i), {22'd0, dec1.pc_out}, {22'd0, vecs[i].exp_pc});
        check($sformatf("row%0d_instr_out", i), {8'd0, dec1.instr_out}, {8'd0, vecs[i].exp_instr});
      end
    end

    // wrap sequence on DUT 2: released from reset, stream 3FE,3FF,000,001
    @(negedge clk);
    rst2 = 1'b0; fen2 = 1'b1; dec2.instr_ready = 1'b1;
    #1;
    check("wrap_reset_addr", {22'd0, rom_addr2}, 32'h3FE);
    first = -1;
    for (int c = 0; c < 8 && first < 0; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      if (dec2.instr_valid) first = c;
    end
    check("wrap_first_valid_cycle", 32'(first), 32'd2);
    if (first >= 0) begin
      for (int k = 0; k < 4; k++) begin
        if (k > 0) begin
          @(negedge clk);
          #1;
        end
        check($sformatf("wrap%0d_valid", k), {31'd0, dec2.instr_valid}, 32'd1);
        check($sformatf("wrap%0d_pc_out", k), {22'd0, dec2.pc_out}, {22'd0, wrap_pc[k]});
        check($sformatf("wrap%0d_instr_out", k), {8'd0, dec2.instr_out}, {8'd0, wrap_in[k]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
